pipelined_control_unit: RTL and testbench

//  MIPS ID-stage control unit, parametrised successor of the single-register opcode decoder.

---
 rtl/ctrl_pkg.sv | 83 ++++++++
 rtl/hazard_detect.sv | 16 +
 rtl/pipelined_control_unit.sv | 108 ++++++++++
 tb/tb_pipelined_control_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the ID-stage control unit: opcodes, ALUOp classes,
// control-bundle bit positions, FSM states and the opcode decode function.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;

  // Bundle layout; ALUOp is stored at its base 2-bit width and widened at the port.
  localparam int CB_ALUOP    = 0;
  localparam int CB_ALUSRC   = 2;
  localparam int CB_REGDST   = 3;
  localparam int CB_MEMWRITE = 4;
  localparam int CB_MEMREAD  = 5;
  localparam int CB_JUMP     = 6;
  localparam int CB_BRNE     = 7;
  localparam int CB_BRANCH   = 8;
  localparam int CB_MEMTOREG = 9;
  localparam int CB_REGWRITE = 10;
  localparam int CB_W        = 11;

  typedef logic [CB_W-1:0] ctrl_bundle_t;

  typedef struct packed {
    logic         legal;
    ctrl_bundle_t b;
  } dec_t;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  function automatic dec_t cu_decode(input logic [5:0] op, input logic has_jump);
    dec_t d;
    d       = '0;
    d.legal = 1'b1;
    case (op)
      OP_RTYPE: begin
        d.b[CB_REGDST]         = 1'b1;
        d.b[CB_ALUOP +: 2]     = ALU_RTYPE;
        d.b[CB_REGWRITE]       = 1'b1;
      end
      OP_LW: begin
        d.b[CB_ALUSRC]         = 1'b1;
        d.b[CB_ALUOP +: 2]     = ALU_ADD;
        d.b[CB_MEMREAD]        = 1'b1;
        d.b[CB_REGWRITE]       = 1'b1;
        d.b[CB_MEMTOREG]       = 1'b1;
      end
      OP_SW: begin
        d.b[CB_ALUSRC]         = 1'b1;
        d.b[CB_MEMWRITE]       = 1'b1;
      end
      OP_BEQ: begin
        d.b[CB_ALUOP +: 2]     = ALU_SUB;
        d.b[CB_BRANCH]         = 1'b1;
      end
      OP_BNE: begin
        d.b[CB_ALUOP +: 2]     = ALU_SUB;
        d.b[CB_BRANCH]         = 1'b1;
        d.b[CB_BRNE]           = 1'b1;
      end
      OP_ADDI: begin
        d.b[CB_ALUSRC]         = 1'b1;
        d.b[CB_REGWRITE]       = 1'b1;
      end
      OP_J: begin
        if (has_jump) d.b[CB_JUMP] = 1'b1;
        else          d.legal      = 1'b0;
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds the instruction in ID.
module hazard_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rt,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  output logic                  o_load_use
);

  // $zero never carries a dependency.
  assign o_load_use = i_ex_mem_read && (i_ex_rt != '0) &&
                      ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

endmodule

// File: rtl/pipelined_control_unit.sv
// MIPS ID-stage control unit: registered ID/EX control bundle, load-use bubble,
// external stall and a RUN/FLUSH sequencer for taken branches and jumps.
module pipelined_control_unit
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W     = 6,
  parameter int REG_ADDR_W   = 5,
  parameter int ALUOP_W      = 2,
  parameter int FLUSH_CYCLES = 1,
  parameter int HAS_JUMP     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_mem_read,
  input  logic                  branch_taken,
  input  logic                  stall_in,
  output logic                  wb_RegWrite_out,
  output logic                  wb_MemtoReg_out,
  output logic                  m_Branch_out,
  output logic                  m_BranchNe_out,
  output logic                  m_Jump_out,
  output logic                  m_MemRead_out,
  output logic                  m_MemWrite_out,
  output logic                  ex_RegDst_out,
  output logic                  ex_ALUSrc_out,
  output logic [ALUOP_W-1:0]    ex_ALUOp_out,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  illegal_op
);

  localparam int         CNT_W    = 3;
  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  ctrl_bundle_t     r_bundle;
  logic             r_illegal;
  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;

  dec_t w_dec;
  logic w_hi_ok;
  logic w_legal;
  logic w_load_use;
  logic w_in_flush;
  logic w_lu;
  logic w_zero;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .i_ex_mem_read (ex_mem_read),
    .i_ex_rt       (ex_rt),
    .i_id_rs       (id_rs),
    .i_id_rt       (id_rt),
    .o_load_use    (w_load_use)
  );

  // Opcode bits above the base 6-bit field must be zero to be legal.
  assign w_hi_ok    = ((opcode >> 6) == '0);
  assign w_dec      = cu_decode(opcode[5:0], HAS_JUMP != 0);
  assign w_legal    = w_dec.legal && w_hi_ok;
  assign w_in_flush = (r_state == ST_FLUSH);
  // A taken branch outranks the load-use stall; the ID slot is dead during a flush.
  assign w_lu       = w_load_use && !branch_taken && !w_in_flush;
  // Final flush edge (cnt==0) decodes the refetched instruction normally.
  assign w_zero     = branch_taken || w_lu || (w_in_flush && (r_cnt != '0)) || !w_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bundle  <= '0;
      r_illegal <= 1'b0;
      r_state   <= ST_RUN;
      r_cnt     <= '0;
    end else if (stall_in) begin
      r_illegal <= 1'b0;
    end else begin
      r_bundle  <= w_zero ? '0 : w_dec.b;
      r_illegal <= !w_legal && !branch_taken && !w_lu && !(w_in_flush && (r_cnt != '0));
      if (branch_taken) begin
        r_state <= ST_FLUSH;
        r_cnt   <= CNT_INIT;
      end else if (w_in_flush) begin
        if (r_cnt == '0) r_state <= ST_RUN;
        else             r_cnt   <= r_cnt - 1'b1;
      end
    end
  end

  assign pc_write        = rst_n && !stall_in && !w_lu;
  assign ifid_write      = rst_n && !stall_in && !w_lu;
  assign ifid_flush      = rst_n && !stall_in && w_in_flush;

  assign wb_RegWrite_out = r_bundle[CB_REGWRITE];
  assign wb_MemtoReg_out = r_bundle[CB_MEMTOREG];
  assign m_Branch_out    = r_bundle[CB_BRANCH];
  assign m_BranchNe_out  = r_bundle[CB_BRNE];
  assign m_Jump_out      = r_bundle[CB_JUMP];
  assign m_MemRead_out   = r_bundle[CB_MEMREAD];
  assign m_MemWrite_out  = r_bundle[CB_MEMWRITE];
  assign ex_RegDst_out   = r_bundle[CB_REGDST];
  assign ex_ALUSrc_out   = r_bundle[CB_ALUSRC];
  assign ex_ALUOp_out    = ALUOP_W'(r_bundle[CB_ALUOP +: 2]);
  assign illegal_op      = r_illegal;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit (FLUSH_CYCLES=2): decode table,
// reset, load-use bubble, flush sequencing, stall freeze and event priority.
module tb_pipelined_control_unit;

  logic       clk, rst_n;
  logic [5:0] opcode;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_mem_read, branch_taken, stall_in;
  logic       wb_RegWrite_out, wb_MemtoReg_out, m_Branch_out, m_BranchNe_out;
  logic       m_Jump_out, m_MemRead_out, m_MemWrite_out, ex_RegDst_out, ex_ALUSrc_out;
  logic [1:0] ex_ALUOp_out;
  logic       pc_write, ifid_write, ifid_flush, illegal_op;

  int checks   = 0;
  int failures = 0;

  pipelined_control_unit #(
    .OPCODE_W(6), .REG_ADDR_W(5), .ALUOP_W(2), .FLUSH_CYCLES(2), .HAS_JUMP(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
    .stall_in(stall_in), .wb_RegWrite_out(wb_RegWrite_out),
    .wb_MemtoReg_out(wb_MemtoReg_out), .m_Branch_out(m_Branch_out),
    .m_BranchNe_out(m_BranchNe_out), .m_Jump_out(m_Jump_out),
    .m_MemRead_out(m_MemRead_out), .m_MemWrite_out(m_MemWrite_out),
    .ex_RegDst_out(ex_RegDst_out), .ex_ALUSrc_out(ex_ALUSrc_out),
    .ex_ALUOp_out(ex_ALUOp_out), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Order: RegDst,ALUSrc,ALUOp[1:0] | Br,BrNe,Jmp,MRd,MWr | RegWr,MemtoReg
  localparam logic [10:0] B_R    = 11'b1_0_10_00000_10;
  localparam logic [10:0] B_LW   = 11'b0_1_00_00010_11;
  localparam logic [10:0] B_SW   = 11'b0_1_00_00001_00;
  localparam logic [10:0] B_BEQ  = 11'b0_0_01_10000_00;
  localparam logic [10:0] B_BNE  = 11'b0_0_01_11000_00;
  localparam logic [10:0] B_ADDI = 11'b0_1_00_00000_10;
  localparam logic [10:0] B_J    = 11'b0_0_00_00100_00;
  localparam logic [10:0] B_ZERO = 11'b0;

  function automatic logic [10:0] bun();
    return {ex_RegDst_out, ex_ALUSrc_out, ex_ALUOp_out, m_Branch_out, m_BranchNe_out,
            m_Jump_out, m_MemRead_out, m_MemWrite_out, wb_RegWrite_out, wb_MemtoReg_out};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0]  ops  [8];
  logic [10:0] exps [8];

  initial begin
    ops[0] = 6'b000000; exps[0] = B_R;
    ops[1] = 6'b100011; exps[1] = B_LW;
    ops[2] = 6'b101011; exps[2] = B_SW;
    ops[3] = 6'b000100; exps[3] = B_BEQ;
    ops[4] = 6'b000101; exps[4] = B_BNE;
    ops[5] = 6'b001000; exps[5] = B_ADDI;
    ops[6] = 6'b000010; exps[6] = B_J;
    ops[7] = 6'b111111; exps[7] = B_ZERO;

    rst_n = 1'b0; opcode = 6'b100011; id_rs = '0; id_rt = '0; ex_rt = '0;
    ex_mem_read = 1'b0; branch_taken = 1'b0; stall_in = 1'b0;
    tick(); tick();
    chk("reset_bundle", 32'(bun()), 32'(B_ZERO));
    chk("reset_illegal", 32'(illegal_op), 32'd0);
    chk("reset_pc_write", 32'(pc_write), 32'd0);
    chk("reset_ifid_flush", 32'(ifid_flush), 32'd0);
    rst_n = 1'b1;

    // Opcode sweep, one edge each
    for (int i = 0; i < 8; i++) begin
      opcode = ops[i];
      tick();
      chk($sformatf("sweep_bundle_%0d", i), 32'(bun()), 32'(exps[i]));
      chk($sformatf("sweep_illegal_%0d", i), 32'(illegal_op), (i == 7) ? 32'd1 : 32'd0);
    end
    chk("run_pc_write", 32'(pc_write), 32'd1);
    chk("run_ifid_write", 32'(ifid_write), 32'd1);
    opcode = 6'b000000;
    tick();
    chk("illegal_one_cycle", 32'(illegal_op), 32'd0);

    // Asynchronous reset between edges, then R-type after release
    opcode = 6'b100011;
    tick();
    chk("pre_reset_lw", 32'(bun()), 32'(B_LW));
    rst_n = 1'b0;
    #1;
    chk("async_reset_bundle", 32'(bun()), 32'(B_ZERO));
    chk("async_reset_pc_write", 32'(pc_write), 32'd0);
    tick();
    rst_n = 1'b1; opcode = 6'b000000;
    tick();
    chk("post_reset_rtype", 32'(bun()), 32'(B_R));

    // Load-use on rs: one bubble, PC/IF-ID held that cycle
    opcode = 6'b000000; ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    #1;
    chk("lu_pc_write", 32'(pc_write), 32'd0);
    chk("lu_ifid_write", 32'(ifid_write), 32'd0);
    tick();
    chk("lu_bubble", 32'(bun()), 32'(B_ZERO));
    chk("lu_no_illegal", 32'(illegal_op), 32'd0);
    ex_mem_read = 1'b0;
    #1;
    chk("lu_release_pc", 32'(pc_write), 32'd1);
    tick();
    chk("lu_after_decode", 32'(bun()), 32'(B_R));
    // Load-use on rt
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd1; id_rt = 5'd5;
    #1;
    chk("lu_rt_pc_write", 32'(pc_write), 32'd0);
    // ex_rt = 0 never hazards
    ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #1;
    chk("lu_zero_pc_write", 32'(pc_write), 32'd1);
    tick();
    chk("lu_zero_decode", 32'(bun()), 32'(B_R));
    ex_mem_read = 1'b0;

    // Taken branch: two flush cycles, then normal decode
    opcode = 6'b001000; branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    chk("br_flush_c1", 32'(ifid_flush), 32'd1);
    chk("br_zero_c1", 32'(bun()), 32'(B_ZERO));
    chk("br_pc_write_c1", 32'(pc_write), 32'd1);
    tick();
    chk("br_flush_c2", 32'(ifid_flush), 32'd1);
    chk("br_zero_c2", 32'(bun()), 32'(B_ZERO));
    tick();
    chk("br_flush_done", 32'(ifid_flush), 32'd0);
    chk("br_decode_after", 32'(bun()), 32'(B_ADDI));

    // Branch coincident with load-use: flush only
    opcode = 6'b100011; ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; branch_taken = 1'b1;
    #1;
    chk("brlu_pc_write", 32'(pc_write), 32'd1);
    chk("brlu_ifid_write", 32'(ifid_write), 32'd1);
    tick();
    branch_taken = 1'b0; ex_mem_read = 1'b0; id_rs = 5'd0;
    chk("brlu_flush", 32'(ifid_flush), 32'd1);
    chk("brlu_zero", 32'(bun()), 32'(B_ZERO));
    tick();
    chk("brlu_flush_c2", 32'(ifid_flush), 32'd1);
    tick();
    chk("brlu_done", 32'(ifid_flush), 32'd0);
    chk("brlu_decode", 32'(bun()), 32'(B_LW));

    // Stall for 3 cycles mid-FLUSH freezes counter and bundle
    opcode = 6'b101011; branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0; stall_in = 1'b1;
    #1;
    chk("st_flush_masked", 32'(ifid_flush), 32'd0);
    chk("st_pc_write", 32'(pc_write), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("st_bundle_%0d", i), 32'(bun()), 32'(B_ZERO));
      chk($sformatf("st_ifid_write_%0d", i), 32'(ifid_write), 32'd0);
    end
    stall_in = 1'b0;
    #1;
    chk("st_release_flush", 32'(ifid_flush), 32'd1);
    tick();
    chk("st_flush_c2", 32'(ifid_flush), 32'd1);
    chk("st_zero_c2", 32'(bun()), 32'(B_ZERO));
    tick();
    chk("st_done", 32'(ifid_flush), 32'd0);
    chk("st_decode", 32'(bun()), 32'(B_SW));

    // Stall in RUN holds the registered bundle
    opcode = 6'b000000; stall_in = 1'b1;
    tick();
    chk("st_run_hold", 32'(bun()), 32'(B_SW));
    opcode = 6'b111111;
    tick();
    chk("st_illegal_suppressed", 32'(illegal_op), 32'd0);
    stall_in = 1'b0; opcode = 6'b000000;
    tick();
    chk("st_run_resume", 32'(bun()), 32'(B_R));

    // Branch again while flushing reloads the counter
    opcode = 6'b000100; branch_taken = 1'b1;
    tick();
    tick();
    branch_taken = 1'b0;
    chk("rl_flush_c1", 32'(ifid_flush), 32'd1);
    tick();
    chk("rl_flush_c2", 32'(ifid_flush), 32'd1);
    tick();
    chk("rl_done", 32'(ifid_flush), 32'd0);
    chk("rl_decode", 32'(bun()), 32'(B_BEQ));

    // Reset mid-FLUSH returns to RUN immediately
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_flush_cleared", 32'(ifid_flush), 32'd0);
    chk("rst_flush_bundle", 32'(bun()), 32'(B_ZERO));
    tick();
    rst_n = 1'b1; opcode = 6'b000101;
    #1;
    chk("rst_run_pc_write", 32'(pc_write), 32'd1);
    chk("rst_run_no_flush", 32'(ifid_flush), 32'd0);
    tick();
    chk("rst_run_decode", 32'(bun()), 32'(B_BNE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
